// File: rtl/phase_timer_pkg.sv
// Shared types and reset-default limits for the phase sequence timer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package phase_timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic int unsigned DEFAULT_LIMIT(input int unsigned idx);
        case (idx)
            0:       return 100;
            1:       return 200;
            2:       return 150;
            3:       return 120;
            default: return 100;
        endcase
    endfunction

endpackage

// File: rtl/phase_limit_table.sv
// Per-phase limit register file, one write port and one combinational read port.
// Latency: writes visible on the read port the cycle after the strobe.
// Backpressure: none; writes to out-of-range indices are dropped.
module phase_limit_table
    import phase_timer_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int NUM_PHASES = 4,
    parameter int PH_W       = $clog2(NUM_PHASES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [PH_W-1:0]  wr_addr_i,
    input  logic [CNT_W-1:0] wr_data_i,
    input  logic [PH_W-1:0]  rd_addr_i,
    output logic [CNT_W-1:0] rd_data_o
);

    logic [CNT_W-1:0] lim_q [NUM_PHASES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PHASES; i++) begin
                lim_q[i] <= CNT_W'(DEFAULT_LIMIT(unsigned'(i)));
            end
        end else if (we_i && (int'(wr_addr_i) < NUM_PHASES)) begin
            lim_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = lim_q[rd_addr_i];

endmodule

// File: rtl/phase_sequence_timer.sv
// Times one phase or auto-advances start_phase..NUM_PHASES-1 against a limit table.
// Latency: done pulses are registered, one cycle after the terminal enabled cycle.
// Backpressure: enable low pauses state and count; start ignored while busy.
module phase_sequence_timer
    import phase_timer_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int NUM_PHASES = 4,
    parameter int PH_W       = $clog2(NUM_PHASES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             start,
    input  logic [PH_W-1:0]  start_phase,
    input  logic             auto_adv,
    input  logic             abort,
    input  logic             cfg_we,
    input  logic [PH_W-1:0]  cfg_addr,
    input  logic [CNT_W-1:0] cfg_data,
    output logic             busy,
    output logic [PH_W-1:0]  phase_cur,
    output logic [CNT_W-1:0] counter_out,
    output logic             phase_done,
    output logic             seq_done
);

    localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(NUM_PHASES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic             auto_q, auto_d;
    logic             phase_done_q, phase_done_d;
    logic             seq_done_q, seq_done_d;

    logic [CNT_W-1:0] lim;
    logic [CNT_W:0]   lim_eff;
    logic [CNT_W:0]   cnt_inc;

    phase_limit_table #(
        .CNT_W      (CNT_W),
        .NUM_PHASES (NUM_PHASES),
        .PH_W       (PH_W)
    ) u_table (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_i      (cfg_we),
        .wr_addr_i (cfg_addr),
        .wr_data_i (cfg_data),
        .rd_addr_i (phase_q),
        .rd_data_o (lim)
    );

    // One extra bit keeps count+1 from wrapping at the all-ones limit.
    assign lim_eff = (lim == '0) ? (CNT_W+1)'(1) : {1'b0, lim};
    assign cnt_inc = {1'b0, count_q} + (CNT_W+1)'(1);

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        phase_d      = phase_q;
        auto_d       = auto_q;
        phase_done_d = 1'b0;
        seq_done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = RUN;
                    count_d = '0;
                    phase_d = start_phase;
                    auto_d  = auto_adv;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (enable) begin
                    if (cnt_inc >= lim_eff) begin
                        count_d      = '0;
                        phase_done_d = 1'b1;
                        if (auto_q && (phase_q < LAST_PHASE)) begin
                            phase_d = phase_q + PH_W'(1);
                        end else begin
                            seq_done_d = 1'b1;
                            state_d    = IDLE;
                        end
                    end else begin
                        count_d = cnt_inc[CNT_W-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            count_q      <= '0;
            phase_q      <= '0;
            auto_q       <= 1'b0;
            phase_done_q <= 1'b0;
            seq_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            phase_q      <= phase_d;
            auto_q       <= auto_d;
            phase_done_q <= phase_done_d;
            seq_done_q   <= seq_done_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign phase_cur   = phase_q;
    assign counter_out = count_q;
    assign phase_done  = phase_done_q;
    assign seq_done    = seq_done_q;

endmodule

// File: tb/tb_phase_sequence_timer.sv
// Directed bench for phase_sequence_timer: default 16-bit/4-phase instance plus an 8-bit/3-phase instance.
module tb_phase_sequence_timer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable, start, auto_adv, abort, cfg_we;
    logic [1:0]  start_phase, cfg_addr;
    logic [15:0] cfg_data;
    logic        busy, phase_done, seq_done;
    logic [1:0]  phase_cur;
    logic [15:0] counter_out;

    logic        b_enable, b_start, b_auto_adv, b_abort, b_cfg_we;
    logic [1:0]  b_start_phase, b_cfg_addr;
    logic [7:0]  b_cfg_data;
    logic        b_busy, b_phase_done, b_seq_done;
    logic [1:0]  b_phase_cur;
    logic [7:0]  b_counter_out;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    phase_sequence_timer dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .start(start),
        .start_phase(start_phase), .auto_adv(auto_adv), .abort(abort),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .busy(busy), .phase_cur(phase_cur), .counter_out(counter_out),
        .phase_done(phase_done), .seq_done(seq_done)
    );

    phase_sequence_timer #(.CNT_W(8), .NUM_PHASES(3)) dut8 (
        .clk(clk), .rst_n(rst_n), .enable(b_enable), .start(b_start),
        .start_phase(b_start_phase), .auto_adv(b_auto_adv), .abort(b_abort),
        .cfg_we(b_cfg_we), .cfg_addr(b_cfg_addr), .cfg_data(b_cfg_data),
        .busy(b_busy), .phase_cur(b_phase_cur), .counter_out(b_counter_out),
        .phase_done(b_phase_done), .seq_done(b_seq_done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Cycles from now until phase_done is seen; returns budget on timeout.
    task automatic wait_done(input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!phase_done && n < budget);
    endtask

    task automatic start_run(input logic [1:0] ph, input logic au);
        start_phase = ph;
        auto_adv    = au;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        enable = 1'b1; start = 1'b0; auto_adv = 1'b0; abort = 1'b0;
        cfg_we = 1'b0; start_phase = 2'd0; cfg_addr = 2'd0; cfg_data = 16'd0;
        b_enable = 1'b1; b_start = 1'b0; b_auto_adv = 1'b0; b_abort = 1'b0;
        b_cfg_we = 1'b0; b_start_phase = 2'd0; b_cfg_addr = 2'd0; b_cfg_data = 8'd0;
        tick();
        tick();
        n_vec++;
        if (busy !== 1'b0 || counter_out !== 16'd0 || phase_cur !== 2'd0) begin
            n_err++;
            $display("FAIL reset_state busy=%b cnt=%0d ph=%0d want 0/0/0", busy, counter_out, phase_cur);
        end
        n_vec++;
        if (phase_done !== 1'b0 || seq_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_pulses pd=%b sd=%b want 0/0", phase_done, seq_done);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single;
        int n;
        start_run(2'd1, 1'b0);
        n_vec++;
        if (busy !== 1'b1 || phase_cur !== 2'd1 || counter_out !== 16'd0) begin
            n_err++;
            $display("FAIL single_start busy=%b ph=%0d cnt=%0d want 1/1/0", busy, phase_cur, counter_out);
        end
        wait_done(400, n);
        n_vec++;
        if (n !== 200) begin
            n_err++;
            $display("FAIL single_len got %0d want 200", n);
        end
        n_vec++;
        if (seq_done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_end sd=%b busy=%b want 1/0", seq_done, busy);
        end
        tick();
        n_vec++;
        if (phase_done !== 1'b0 || seq_done !== 1'b0 || phase_cur !== 2'd1) begin
            n_err++;
            $display("FAIL single_after pd=%b sd=%b ph=%0d want 0/0/1", phase_done, seq_done, phase_cur);
        end
    endtask

    task automatic test_auto;
        int exp_t[4] = '{100, 300, 450, 570};
        int total = 0;
        int n;
        logic [1:0] exp_ph;
        logic exp_sd;
        start_run(2'd0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            wait_done(300, n);
            total += n;
            exp_ph = (k < 3) ? 2'(k + 1) : 2'd3;
            exp_sd = (k == 3);
            n_vec++;
            if (total !== exp_t[k] || seq_done !== exp_sd || phase_cur !== exp_ph || busy !== !exp_sd) begin
                n_err++;
                $display("FAIL auto_phase%0d t=%0d sd=%b ph=%0d busy=%b want t=%0d sd=%b ph=%0d busy=%b",
                         k, total, seq_done, phase_cur, busy, exp_t[k], exp_sd, exp_ph, !exp_sd);
            end
        end
    endtask

    task automatic test_pause_abort;
        int n;
        start_run(2'd0, 1'b1);
        repeat (10) tick();
        enable = 1'b0;
        repeat (50) tick();
        n_vec++;
        if (counter_out !== 16'd10 || busy !== 1'b1 || phase_done !== 1'b0) begin
            n_err++;
            $display("FAIL pause_hold cnt=%0d busy=%b pd=%b want 10/1/0", counter_out, busy, phase_done);
        end
        enable = 1'b1;
        wait_done(300, n);
        n_vec++;
        if (60 + n !== 150 || phase_cur !== 2'd1) begin
            n_err++;
            $display("FAIL pause_len got %0d ph=%0d want 150 ph=1", 60 + n, phase_cur);
        end
        repeat (10) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || counter_out !== 16'd0 || phase_done !== 1'b0 || seq_done !== 1'b0) begin
            n_err++;
            $display("FAIL abort busy=%b cnt=%0d pd=%b sd=%b want 0/0/0/0", busy, counter_out, phase_done, seq_done);
        end
        start_run(2'd2, 1'b0);
        n_vec++;
        if (busy !== 1'b1 || phase_cur !== 2'd2) begin
            n_err++;
            $display("FAIL restart busy=%b ph=%0d want 1/2", busy, phase_cur);
        end
        abort = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL start_abort_idle busy=%b want 0", busy);
        end
    endtask

    task automatic test_config;
        int n;
        cfg_we = 1'b1; cfg_addr = 2'd2; cfg_data = 16'd0;
        tick();
        cfg_we = 1'b0;
        start_run(2'd2, 1'b1);
        wait_done(10, n);
        n_vec++;
        if (n !== 1 || phase_cur !== 2'd3 || seq_done !== 1'b0) begin
            n_err++;
            $display("FAIL lim0 len=%0d ph=%0d sd=%b want 1/3/0", n, phase_cur, seq_done);
        end
        repeat (20) tick();
        cfg_we = 1'b1; cfg_addr = 2'd3; cfg_data = 16'd5;
        tick();
        cfg_we = 1'b0;
        n_vec++;
        if (counter_out !== 16'd21 || phase_done !== 1'b0) begin
            n_err++;
            $display("FAIL cfg_live_wr cnt=%0d pd=%b want 21/0", counter_out, phase_done);
        end
        tick();
        n_vec++;
        if (phase_done !== 1'b1 || seq_done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL cfg_live_end pd=%b sd=%b busy=%b want 1/1/0", phase_done, seq_done, busy);
        end
    endtask

    task automatic test_reset_mid_run;
        int n;
        start_run(2'd0, 1'b0);
        repeat (37) tick();
        n_vec++;
        if (counter_out !== 16'd37) begin
            n_err++;
            $display("FAIL prereset_cnt got %0d want 37", counter_out);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0 || counter_out !== 16'd0 || phase_cur !== 2'd0 || phase_done !== 1'b0 || seq_done !== 1'b0) begin
            n_err++;
            $display("FAIL midrun_reset busy=%b cnt=%0d ph=%0d pd=%b sd=%b want all 0",
                     busy, counter_out, phase_cur, phase_done, seq_done);
        end
        tick();
        rst_n = 1'b1;
        tick();
        start_run(2'd2, 1'b0);
        wait_done(300, n);
        n_vec++;
        if (n !== 150) begin
            n_err++;
            $display("FAIL table_default_ph2 len=%0d want 150", n);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        start_run(2'd3, 1'b0);
        start = 1'b1;
        start_phase = 2'd0;
        wait_done(300, n);
        n_vec++;
        if (n !== 120 || busy !== 1'b0 || phase_cur !== 2'd3) begin
            n_err++;
            $display("FAIL b2b_end len=%0d busy=%b ph=%0d want 120/0/3", n, busy, phase_cur);
        end
        tick();
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b1 || phase_cur !== 2'd0) begin
            n_err++;
            $display("FAIL b2b_restart busy=%b ph=%0d want 1/0", busy, phase_cur);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_sweep8;
        int n;
        int maxc;
        b_cfg_we = 1'b1; b_cfg_addr = 2'd0; b_cfg_data = 8'd255;
        tick();
        b_cfg_addr = 2'd3; b_cfg_data = 8'd7;
        tick();
        b_cfg_we = 1'b0;
        b_start_phase = 2'd0; b_auto_adv = 1'b0; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        n = 0;
        maxc = 0;
        do begin
            tick();
            n++;
            if (int'(b_counter_out) > maxc) maxc = int'(b_counter_out);
        end while (!b_phase_done && n < 600);
        n_vec++;
        if (n !== 255 || maxc !== 254 || b_seq_done !== 1'b1) begin
            n_err++;
            $display("FAIL sweep255 len=%0d maxcnt=%0d sd=%b want 255/254/1", n, maxc, b_seq_done);
        end
        b_start_phase = 2'd1; b_auto_adv = 1'b1; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!b_seq_done && n < 600);
        n_vec++;
        if (n !== 350 || b_phase_cur !== 2'd2 || b_busy !== 1'b0) begin
            n_err++;
            $display("FAIL sweep_auto3 len=%0d ph=%0d busy=%b want 350/2/0", n, b_phase_cur, b_busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_auto();
        test_pause_abort();
        test_config();
        test_reset_mid_run();
        test_back_to_back();
        test_sweep8();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
